// File: rtl/uart_pkg.sv
// Shared UART receive/transmit definitions: data width, default bit time, FSM states.
// PARITY exists only when UART_RECV_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int BPS_DEFAULT = 1250;  // 12 MHz / 9600 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RECV_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_recv_if.sv
// Serial line plus received-byte status bundle between a UART receiver and its user.
// The slave modport is the receiver; the master modport drives rx and consumes results.
interface uart_recv_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 rx_busy;

  modport master (output rx, input rx_data, rx_valid, frame_err, parity_err, rx_busy);
  modport slave  (input rx, output rx_data, rx_valid, frame_err, parity_err, rx_busy);

endinterface

// File: rtl/uart_rx_baud.sv
// Bit-time counter for the UART receiver: counts 0..BPS_PARA-1 while enabled and
// flags the mid-bit sample point.
module uart_rx_baud #(
  parameter int BPS_PARA = 1250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = $clog2(BPS_PARA);
  localparam logic [CW-1:0] LAST = CW'(BPS_PARA - 1);
  localparam logic [CW-1:0] MID  = CW'(BPS_PARA >> 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (!en || restart) cnt <= '0;
    else if (cnt == LAST)    cnt <= '0;
    else                     cnt <= cnt + CW'(1);
  end

  assign tick = en && !restart && (cnt == MID);

endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8 data bits LSB first, one stop bit, BPS_PARA clk cycles per bit.
// Defining UART_RECV_PARITY_EN adds an even-parity bit between data and stop.
//
// state  | meaning
// IDLE   | line idle, waiting for a 1->0 edge on synchronized rx
// START  | confirming start bit at mid-bit
// DATA   | shifting in 8 data bits, LSB first
// PARITY | sampling parity bit (UART_RECV_PARITY_EN only)
// STOP   | checking stop bit, issuing result pulse
// BREAK  | stop bit was low; waiting for line to return high
module uart_recv
  import uart_pkg::*;
#(
  parameter int BPS_PARA = BPS_DEFAULT
) (
  input logic         clk,
  input logic         rst_n,
  uart_recv_if.slave  bus
);

  logic                 rx_meta, rx_s, rx_prev;
  rx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q;
  logic                 tick, baud_en, start_edge;
`ifdef UART_RECV_PARITY_EN
  logic                 par_err, perr_q;
`else
  localparam logic      par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = (state == IDLE) && rx_prev && !rx_s;
  assign baud_en    = (state != IDLE) && (state != BREAK);

  uart_rx_baud #(.BPS_PARA(BPS_PARA)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (baud_en),
    .restart (start_edge),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      par_err <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_edge) begin
            state   <= START;
            bit_idx <= '0;
`ifdef UART_RECV_PARITY_EN
            par_err <= 1'b0;
`endif
          end
        end
        START: begin
          if (tick) state <= rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RECV_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_err <= ^{shift, rx_s};
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              state <= IDLE;
              // a parity failure keeps the previous good byte visible
              if (par_err) begin
`ifdef UART_RECV_PARITY_EN
                perr_q <= 1'b1;
`endif
              end else begin
                data_q  <= shift;
                valid_q <= 1'b1;
              end
            end else begin
              ferr_q <= 1'b1;
              state  <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy   = (state != IDLE);
`ifdef UART_RECV_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Randomized bench for uart_recv at 16 clk/bit; a frame-level model predicts each
// frame's single result pulse, its data and its cycle, compared against a monitor.
module tb_uart_recv;

  localparam int BPS = 16;
`ifdef UART_RECV_PARITY_EN
  localparam int STOP_IDX = 10;
  localparam bit PAR_EN   = 1'b1;
`else
  localparam int STOP_IDX = 9;
  localparam bit PAR_EN   = 1'b0;
`endif
  // 2 sync flops + edge detect + half a bit to start mid + whole bits to stop mid + output reg
  localparam int LAT = 4 + BPS / 2 + STOP_IDX * BPS;

  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_PERR  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_recv_if bus ();

  uart_recv #(.BPS_PARA(BPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  logic [7:0] last_good = 8'h00;

  int ob_kind[$], ob_data[$], ob_cyc[$];
  int ex_kind[$], ex_data[$], ex_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_busy) busy_cnt++;
    if (rst_n && (bus.rx_valid || bus.frame_err || bus.parity_err)) begin
      chk("pulse_exclusive", $countones({bus.rx_valid, bus.frame_err, bus.parity_err}), 1);
      ob_kind.push_back(bus.rx_valid ? K_VALID : (bus.frame_err ? K_FERR : K_PERR));
      ob_data.push_back(int'(bus.rx_data));
      ob_cyc.push_back(cyc);
    end
  end

  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (BPS) @(negedge clk);
  endtask

  // frame-level reference: one pulse per frame, kind from stop/parity rules
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    int kind;
    kind = K_VALID;
    if (!stop) kind = K_FERR;
    else if (PAR_EN && ((^d) ^ pbit)) kind = K_PERR;
    if (kind == K_VALID) last_good = d;
    ex_kind.push_back(kind);
    ex_data.push_back(int'(last_good));
    ex_cyc.push_back(cyc + LAT);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic settle(input string tag, input int n);
    int m;
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
    chk({tag, "_n_events"}, ob_kind.size(), ex_kind.size());
    m = (ob_kind.size() < ex_kind.size()) ? ob_kind.size() : ex_kind.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_kind"}, ob_kind[i], ex_kind[i]);
      chk({tag, "_data"}, ob_data[i], ex_data[i]);
      chk({tag, "_latency"}, ob_cyc[i], ex_cyc[i]);
    end
    chk({tag, "_idle_busy"}, bus.rx_busy, 1'b0);
    chk({tag, "_rx_data"}, bus.rx_data, last_good);
    ob_kind.delete(); ob_data.delete(); ob_cyc.delete();
    ex_kind.delete(); ex_data.delete(); ex_cyc.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop, pbit;
    int         gap;

    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    chk("rst_parity_err", bus.parity_err, 1'b0);
    chk("rst_rx_busy", bus.rx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'h55, 1'b1, ^8'h55);
    settle("f55", 2 * BPS);

    send_frame(8'hA3, 1'b1, ^8'hA3);
    send_frame(8'h0F, 1'b1, ^8'h0F);
    settle("b2b", 2 * BPS);

    busy_cnt = 0;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    settle("false_start", 3 * BPS);
    chk("false_start_busy_seen", busy_cnt > 0, 1'b1);
    chk("false_start_busy_lt16", busy_cnt < 16, 1'b1);

    send_frame(8'h3C, 1'b0, ^8'h3C);
    bus.rx = 1'b0;
    repeat (50) @(negedge clk);
    settle("frame_err", 3 * BPS);
    settle("after_break", 2 * BPS);

    d = 8'hC6;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.rx = d[4];
    repeat (BPS / 2) @(negedge clk);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_rx_data", bus.rx_data, 8'h00);
    chk("midrst_rx_busy", bus.rx_busy, 1'b0);
    last_good = 8'h00;
    rst_n = 1'b1;
    repeat (2 * BPS) @(negedge clk);
    settle("abort", BPS);
    send_frame(8'h81, 1'b1, ^8'h81);
    settle("after_rst", 2 * BPS);

`ifdef UART_RECV_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    settle("par_good", 2 * BPS);
    send_frame(8'h07, 1'b1, 1'b0);
    settle("par_bad", 2 * BPS);
`endif

    for (int f = 0; f < 30; f++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      pbit = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, stop, pbit);
      gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      for (int g = 0; g < gap; g++) drive_bit(1'b1);
    end
    settle("random", 2 * BPS);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter BPS_PARA, default 1250, SHALL be the clk cycles per bit (12 MHz / 9600 baud), legal range 16..8191.
REQ-003 Port clk, input, 1 bit, SHALL be the system clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 Port rx, input, 1 bit, SHALL be the asynchronous serial line; it idles high.
REQ-006 Port rx_data, output, 8 bits, SHALL hold the last correctly received byte.
REQ-007 Port rx_valid, output, 1 bit, SHALL be a one-cycle pulse marking a new byte in rx_data.
REQ-008 Port frame_err, output, 1 bit, SHALL be a one-cycle pulse marking a bad stop bit.
REQ-009 Port parity_err, output, 1 bit, SHALL be a one-cycle pulse marking a parity mismatch.
REQ-010 Port rx_busy, output, 1 bit, SHALL be high whenever the FSM is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; synchronizer flops reset to 1.
REQ-012 States SHALL be IDLE, START, DATA, PARITY (only with the macro), STOP, and BREAK.
REQ-013 IDLE SHALL go to START on the first cycle rx_s is 0 after being 1, and clear the bit counter.
REQ-014 The bit-time counter SHALL run 0..BPS_PARA-1 and wrap; it is held at 0 in IDLE and BREAK.
REQ-015 The counter SHALL restart at 0 on each START entry, and the sample tick SHALL fire when counter == BPS_PARA>>1.
REQ-016 START, at the tick: rx_s==1 is a false start and SHALL return to IDLE with no output pulse; rx_s==0 SHALL go to DATA.
REQ-017 DATA SHALL sample 8 bits LSB first on 8 successive ticks into a shift register, using a 3-bit index that wraps 7->0.
REQ-018 After the 8th bit the FSM SHALL go to PARITY if the macro is defined, otherwise to STOP.
REQ-019 STOP, at the tick with rx_s==1: rx_data SHALL load the shift register and rx_valid SHALL pulse in the next cycle, unless a parity error was latched.
REQ-020 With a parity error latched, a good stop bit SHALL pulse parity_err instead of rx_valid, and rx_data SHALL stay unchanged.
REQ-021 STOP, at the tick with rx_s==0: frame_err SHALL pulse next cycle, rx_data SHALL stay unchanged, and the FSM SHALL go to BREAK.
REQ-022 BREAK SHALL wait until rx_s==1, then go to IDLE; a line held low SHALL NOT re-trigger reception.
REQ-023 Latency from the synchronized stop-bit mid-sample to rx_valid SHALL be exactly 1 clk.
REQ-024 rx_valid, frame_err and parity_err SHALL be mutually exclusive, and at most one pulse SHALL occur per frame.
REQ-025 A new start edge SHALL be accepted in the cycle after the STOP-state transition back to IDLE, which supports back-to-back frames.

Reset
REQ-026 On reset: the FSM SHALL go to IDLE, counters to 0, rx_data=8'h00, and rx_valid=frame_err=parity_err=rx_busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL resume only on a fresh 1->0 edge.

Configuration
REQ-028 Macro UART_RECV_PARITY_EN, when defined, SHALL add the PARITY state: one bit sampled at the tick, checked for even parity (XOR of 8 data bits plus parity bit == 0), with a mismatch latched for STOP.
REQ-029 Without UART_RECV_PARITY_EN, the frame SHALL be 8N1, the PARITY state SHALL be absent, and parity_err SHALL be tied to 0.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8, and the default BPS_PARA constant, shared with the transmit side.
REQ-031 Sub-module uart_rx_baud SHALL contain the bit-time counter and produce the sample tick from enable/restart inputs.

Verification (BPS_PARA=16 for simulation)
REQ-032 Send frame 0x55, 8N1, at 16 clk/bit -> exactly one rx_valid pulse, rx_data=8'h55, and frame_err=0.
REQ-033 Send 0xA3 then 0x0F back-to-back with no idle gap -> two rx_valid pulses, rx_data 8'hA3 then 8'h0F.
REQ-034 Pulse rx low for 4 clk, then return high -> false start, no pulse, rx_busy high for fewer than 16 clk.
REQ-035 Send 0x3C with stop bit 0, then hold rx low for 50 clk, then high -> one frame_err pulse, rx_data unchanged, and no further pulses until the next edge.
REQ-036 Assert rst_n low at data bit 4 of a frame, release, then send 0x81 -> no pulse for the aborted frame, then rx_valid with rx_data=8'h81.
REQ-037 With UART_RECV_PARITY_EN, send 0x07 with parity bit 1 and then 0 -> rx_valid with 8'h07, then parity_err with rx_data still 8'h07.
